// File: rtl/bus_pkg.sv
// Shared bus-fabric helpers: index-width sizing for select/arbitration logic.
package bus_pkg;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/onehot_chk.sv
// One-hot select checker: flags empty/multiple selects and encodes the lowest set bit.
module onehot_chk
   import bus_pkg::*;
#(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  sel_i,
   output logic [IW-1:0] sel_idx_o,
   output logic          sel_none_o,
   output logic          sel_multi_o
);

   logic          seen;
   logic          multi;
   logic [IW-1:0] idx;

   // Only 0 / 1 / >=2 matters, so track "seen one already" instead of a popcount.
   always_comb begin
      seen  = 1'b0;
      multi = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel_i[i]) begin
            if (seen) begin
               multi = 1'b1;
            end else begin
               idx = IW'(i);
            end
            seen = 1'b1;
         end
      end
   end

   assign sel_idx_o   = idx;
   assign sel_none_o  = ~seen;
   assign sel_multi_o = multi;

endmodule

// File: rtl/onehot_data_mux.sv
// AND-OR data mux driven by a one-hot select, with optional output register
// and a sticky flag recording any multi-hot select since reset.
module onehot_data_mux
   import bus_pkg::*;
#(
   parameter  int unsigned N_INPUTS     = 2,
   parameter  int unsigned W_INPUT      = 32,
   parameter  bit          REGISTER_OUT = 1'b0,
   localparam int unsigned IW           = idx_width(N_INPUTS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_INPUTS*W_INPUT-1:0]   in,
   input  logic [N_INPUTS-1:0]           sel,
   output logic [W_INPUT-1:0]            out,
   output logic [IW-1:0]                 sel_idx,
   output logic                          sel_none,
   output logic                          sel_multi,
   output logic                          sel_err_sticky
);

   logic [W_INPUT-1:0] mux_d;
   logic               none_d;
   logic               multi_d;
   logic               err_q;

   onehot_chk #(
      .N (N_INPUTS)
   ) u_chk (
      .sel_i       (sel),
      .sel_idx_o   (sel_idx),
      .sel_none_o  (none_d),
      .sel_multi_o (multi_d)
   );

   // No priority in the data path: overlapping selects OR their words together.
   always_comb begin
      mux_d = '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
         mux_d = mux_d | (in[i*W_INPUT +: W_INPUT] & {W_INPUT{sel[i]}});
      end
   end

   if (REGISTER_OUT) begin : g_reg
      logic [W_INPUT-1:0] out_q;
      logic               none_q;
      logic               multi_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            out_q   <= '0;
            none_q  <= 1'b1;
            multi_q <= 1'b0;
         end else begin
            out_q   <= mux_d;
            none_q  <= none_d;
            multi_q <= multi_d;
         end
      end

      assign out       = out_q;
      assign sel_none  = none_q;
      assign sel_multi = multi_q;
   end else begin : g_comb
      assign out       = mux_d;
      assign sel_none  = none_d;
      assign sel_multi = multi_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (multi_d) begin
         err_q <= 1'b1;
      end
   end

   assign sel_err_sticky = err_q;

endmodule

// File: tb/tb_onehot_data_mux.sv
// Bench for onehot_data_mux: combinational, registered and 4-input instances.
module tb_onehot_data_mux;

   typedef struct packed {
      logic [31:0] out;
      logic        idx;
      logic        none;
      logic        multi;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in2;
   logic [1:0]  sel2;
   logic [31:0] in4;
   logic [3:0]  sel4;

   logic [31:0] out_c, out_r;
   logic        idx_c, idx_r;
   logic        none_c, none_r, multi_c, multi_r, sticky_c, sticky_r;
   logic [7:0]  out_4;
   logic [1:0]  idx_4;
   logic        none_4, multi_4, sticky_4;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   exp_t        comb_q[$];
   exp_t        reg_q[$];

   always #5 clk = ~clk;

   onehot_data_mux #(.N_INPUTS(2), .W_INPUT(32), .REGISTER_OUT(1'b0)) u_comb (
      .clk(clk), .rst(rst), .in(in2), .sel(sel2), .out(out_c), .sel_idx(idx_c),
      .sel_none(none_c), .sel_multi(multi_c), .sel_err_sticky(sticky_c));

   onehot_data_mux #(.N_INPUTS(2), .W_INPUT(32), .REGISTER_OUT(1'b1)) u_reg (
      .clk(clk), .rst(rst), .in(in2), .sel(sel2), .out(out_r), .sel_idx(idx_r),
      .sel_none(none_r), .sel_multi(multi_r), .sel_err_sticky(sticky_r));

   onehot_data_mux #(.N_INPUTS(4), .W_INPUT(8), .REGISTER_OUT(1'b0)) u_four (
      .clk(clk), .rst(rst), .in(in4), .sel(sel4), .out(out_4), .sel_idx(idx_4),
      .sel_none(none_4), .sel_multi(multi_4), .sel_err_sticky(sticky_4));

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_mux2(input logic [63:0] d, input logic [1:0] s);
      logic [31:0] r;
      r = 32'h0;
      if (s[0]) r = r | d[31:0];
      if (s[1]) r = r | d[63:32];
      return r;
   endfunction

   // Drive one 2-input transaction, check the combinational instance in-cycle
   // and the registered instance after the following edge.
   task automatic cycle2(input logic [63:0] din, input logic [1:0] s, input logic [31:0] eo,
                         input logic ei, input logic en, input logic em);
      exp_t e, c, r;
      e = '{out: eo, idx: ei, none: en, multi: em};
      in2  = din;
      sel2 = s;
      comb_q.push_back(e);
      reg_q.push_back(e);
      #1;
      c = comb_q.pop_front();
      check_eq("comb_out",   out_c,   c.out);
      check_eq("comb_idx",   idx_c,   c.idx);
      check_eq("comb_none",  none_c,  c.none);
      check_eq("comb_multi", multi_c, c.multi);
      @(posedge clk); #1;
      r = reg_q.pop_front();
      check_eq("reg_out",   out_r,   r.out);
      check_eq("reg_none",  none_r,  r.none);
      check_eq("reg_multi", multi_r, r.multi);
      check_eq("reg_idx",   idx_r,   r.idx);
   endtask

   initial begin
      logic [7:0]  walk_exp [4];
      logic [63:0] din;
      logic [1:0]  s;
      logic [31:0] ref4;
      logic [1:0]  k4;

      walk_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst  = 1'b1;
      in2  = '0;
      sel2 = '0;
      in4  = '0;
      sel4 = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_reg_out",   out_r,    32'h0);
      check_eq("rst_reg_none",  none_r,   1'b1);
      check_eq("rst_reg_multi", multi_r,  1'b0);
      check_eq("rst_sticky_c",  sticky_c, 1'b0);
      check_eq("rst_sticky_r",  sticky_r, 1'b0);
      check_eq("rst_sticky_4",  sticky_4, 1'b0);
      check_eq("rst_comb_none", none_c,   1'b1);
      rst = 1'b0;

      // registered latency and mid-stream reset
      in2  = {32'hCAFE0001, 32'h0};
      sel2 = 2'b10;
      #1;
      check_eq("reg_pre_edge", out_r, 32'h0);
      check_eq("reg_idx_comb", idx_r, 1'b1);
      @(posedge clk); #1;
      check_eq("reg_post_edge", out_r,  32'hCAFE0001);
      check_eq("reg_post_none", none_r, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("reg_midrst_out",  out_r,  32'h0);
      check_eq("reg_midrst_none", none_r, 1'b1);
      check_eq("comb_in_rst_out", out_c,  32'hCAFE0001);
      check_eq("comb_in_rst_none", none_c, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("reg_resume", out_r, 32'hCAFE0001);

      // directed 2-input patterns
      cycle2({32'hDEADBEEF, 32'h12345678}, 2'b01, 32'h12345678, 1'b0, 1'b0, 1'b0);
      cycle2({32'hDEADBEEF, 32'h12345678}, 2'b10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
      cycle2({32'hDEADBEEF, 32'h12345678}, 2'b00, 32'h00000000, 1'b0, 1'b1, 1'b0);
      check_eq("sticky_c_clean", sticky_c, 1'b0);
      cycle2({32'hF0F00000, 32'h00000F0F}, 2'b11, 32'hF0F00F0F, 1'b0, 1'b0, 1'b1);
      check_eq("sticky_c_set", sticky_c, 1'b1);
      check_eq("sticky_r_set", sticky_r, 1'b1);
      cycle2({32'hF0F00000, 32'h00000F0F}, 2'b01, 32'h00000F0F, 1'b0, 1'b0, 1'b0);
      check_eq("sticky_c_hold", sticky_c, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("sticky_c_clr", sticky_c, 1'b0);
      check_eq("sticky_r_clr", sticky_r, 1'b0);
      rst = 1'b0;

      // 4-input walk
      in4 = 32'h44332211;
      for (int unsigned i = 0; i < 4; i++) begin
         sel4 = 4'(1 << i);
         #1;
         check_eq("walk_out",   out_4,   walk_exp[i]);
         check_eq("walk_idx",   idx_4,   2'(i));
         check_eq("walk_multi", multi_4, 1'b0);
      end
      sel4 = 4'b0110;
      #1;
      check_eq("four_multi_out", out_4,   8'h33);
      check_eq("four_multi_idx", idx_4,   2'd1);
      check_eq("four_multi",     multi_4, 1'b1);
      @(posedge clk); #1;
      check_eq("four_sticky", sticky_4, 1'b1);
      sel4 = 4'b0000;
      #1;
      check_eq("four_none_out", out_4,  8'h00);
      check_eq("four_none",     none_4, 1'b1);
      check_eq("four_none_idx", idx_4,  2'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // randomised one-hot traffic
      for (int unsigned n = 0; n < 10000; n++) begin
         din  = {$urandom, $urandom};
         s    = 2'b01 << $urandom_range(0, 1);
         in4  = $urandom;
         k4   = 2'($urandom_range(0, 3));
         sel4 = 4'b0001 << k4;
         ref4 = in4 >> (8 * k4);
         cycle2(din, s, model_mux2(din, s), s[1], 1'b0, 1'b0);
         check_eq("rand4_out",   out_4,   ref4[7:0]);
         check_eq("rand4_idx",   idx_4,   k4);
         check_eq("rand4_multi", multi_4, 1'b0);
      end
      check_eq("rand_sticky_c", sticky_c, 1'b0);
      check_eq("rand_sticky_4", sticky_4, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/onehot_data_mux.md
Name: onehot_data_mux

Overview:
- Parameterised AND-OR multiplexer. It selects one W_INPUT-bit word from N_INPUTS packed inputs using a one-hot select vector.
- Used in bus fabric data-phase return paths, e.g. a 1:N AHB-lite splitter muxing slave HRDATA back to the master by registered data-phase slave select.
- Default configuration is purely combinational, with zero-cycle latency.
- Optional output register and select-legality checking are provided for timing and debug use.

Parameters:
- N_INPUTS, 2, number of input words (>=1).
- W_INPUT, 32, width of each input word and of out (>=1).
- REGISTER_OUT, 0, 0 = out is combinational; 1 = out, sel_none and sel_multi are registered (1-cycle latency).

Ports:
- clk  input  1  clock; used only by the output register and sticky flag.
- rst  input  1  synchronous active-high reset.
- in  input  N_INPUTS*W_INPUT  packed inputs; word i is in[i*W_INPUT +: W_INPUT].
- sel  input  N_INPUTS  one-hot select; bit i selects word i.
- out  output  W_INPUT  muxed word.
- sel_idx  output  max(1,$clog2(N_INPUTS))  binary index of the lowest set sel bit; 0 when sel==0.
- sel_none  output  1  sel==0.
- sel_multi  output  1  more than one sel bit set.
- sel_err_sticky  output  1  set on any cycle sel_multi is high (combinational value); held until rst.

Behaviour:
- Mux function: out = OR over i of (word i AND replicate(sel[i])).
- sel==0 -> out = 0.
- Exactly one bit i set -> out = word i exactly.
- Multiple bits set -> out = bitwise OR of all selected words. This is defined behaviour, not X, and sel_multi flags it.
- No priority logic in the data path. sel_idx alone uses lowest-index priority.
- REGISTER_OUT=0:
  - out, sel_idx, sel_none and sel_multi are combinational, with no dependence on clk or rst.
  - They follow inputs in the same cycle.
- REGISTER_OUT=1:
  - out, sel_none and sel_multi update on the posedge clk following their inputs.
  - rst forces out=0, sel_none=1, sel_multi=0 at the next posedge.
  - sel_idx stays combinational.
- sel_err_sticky:
  - Registered in both modes.
  - Reset value 0; rst clears it at the posedge.
  - Set at the posedge when the combinational sel_multi is 1 and rst is 0.
  - rst wins over a simultaneous set.
- Reset mid-operation:
  - Combinational outputs are unaffected.
  - Registered outputs take their reset values on the next posedge regardless of in/sel, and resume tracking on the first posedge after rst drops.
- N_INPUTS=1: out = in & replicate(sel[0]); sel_multi is constant 0; sel_idx width is 1 and constant 0.
- No combinational path from any output back to any input. The block must not introduce latches.
- Width rules: the count of set sel bits needs only to be compared as 0, 1 or >=2, so a full popcount is not required.

Decomposition:
- Shared package (bus_pkg): function to compute index width, max(1,$clog2(n)).
- Natural sub-module: onehot_chk.
  - Computes sel_none, sel_multi and sel_idx from sel.
  - Pure combinational.
  - Reusable by arbiters.
- Data path and optional register stay in onehot_data_mux.

Test Plan (all with N_INPUTS=2, W_INPUT=32 unless stated):
- REGISTER_OUT=0; in={32'hDEADBEEF,32'h12345678}; sel=2'b01 -> out=32'h12345678, sel_idx=0, sel_none=0, sel_multi=0 in the same cycle. sel=2'b10 -> out=32'hDEADBEEF, sel_idx=1.
- sel=2'b00, same in -> out=32'h00000000, sel_none=1, sel_idx=0.
- sel=2'b11; in={32'hF0F0_0000,32'h0000_0F0F} -> out=32'hF0F0_0F0F, sel_multi=1, sel_idx=0. Next posedge -> sel_err_sticky=1 and it stays 1 after sel returns to 2'b01. Pulse rst -> sel_err_sticky=0.
- REGISTER_OUT=1; sel=2'b10, in word1=32'hCAFE0001 -> out=0 before the edge and 32'hCAFE0001 after one posedge. Assert rst mid-stream -> out=0, sel_none=1 at the next posedge.
- N_INPUTS=4, W_INPUT=8; in={8'h44,8'h33,8'h22,8'h11}; walk sel through 0001, 0010, 0100, 1000 -> out 8'h11, 8'h22, 8'h33, 8'h44 and sel_idx 0, 1, 2, 3.
- Randomised one-hot sel against the reference model OR(in_i & sel_i) over 10k cycles -> zero mismatches and sel_multi never asserted.
